// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the LEGv8 datapath.
// Walks every instruction through FETCH/DECODE/EXEC/MEM/WB. It decodes the
// latched opcode into datapath enables and the ALUop consumed by ALUControl.
// Fetch and data accesses stall on the MemReady handshake.
// An unknown opcode or a memory that never answers parks the machine in TRAP.
// Only a reset leaves TRAP.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [10:0] Opcode,
    input  logic        MemReady,
    output logic [1:0]  ALUop,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        Branch,
    output logic        UncondBranch,
    output logic        InstrDone,
    output logic        Illegal,
    output logic        BusErr,
    output logic [2:0]  State
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_R,
        C_LDUR,
        C_STUR,
        C_CBZ,
        C_B
    } iclass_t;

    // The count leaves this value on the last stalled cycle that is still allowed.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [10:0]       opc_q;
    iclass_t           cls;

    // Map an 11-bit opcode field onto the instruction classes this FSM sequences.
    function automatic iclass_t classify(input logic [10:0] op);
        iclass_t c;
        c = C_NONE;
        if (op == 11'b11111000010)
            c = C_LDUR;
        else if (op == 11'b11111000000)
            c = C_STUR;
        else if (op[10:3] == 8'b10110100)
            c = C_CBZ;
        else if (op[10:5] == 6'b000101)
            c = C_B;
        else if (op == 11'b10001011000 || op == 11'b11001011000 ||
                 op == 11'b10001010000 || op == 11'b10101010000)
            c = C_R;
        return c;
    endfunction

    // All datapath outputs after DECODE are driven from the latched opcode.
    // The live IR field therefore never reaches an output.
    assign cls   = classify(opc_q);
    assign State = state;

    // State sequencing, MemReady wait counter, opcode latch and sticky error flags.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= S_RST;
            wait_cnt <= '0;
            opc_q    <= '0;
            Illegal  <= 1'b0;
            BusErr   <= 1'b0;
        end else begin
            case (state)
                S_RST: begin
                    state    <= S_FETCH;
                    wait_cnt <= '0;
                end
                S_FETCH: begin
                    // A completion in the same cycle as the timeout wins.
                    if (MemReady) begin
                        state <= S_DECODE;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        state  <= S_TRAP;
                        BusErr <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    opc_q <= Opcode;
                    if (classify(Opcode) == C_NONE) begin
                        state   <= S_TRAP;
                        Illegal <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    case (cls)
                        C_R:            state <= S_WB;
                        C_LDUR, C_STUR: state <= S_MEM;
                        default:        state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (MemReady) begin
                        wait_cnt <= '0;
                        state    <= (cls == C_LDUR) ? S_WB : S_FETCH;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        state  <= S_TRAP;
                        BusErr <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    state    <= S_FETCH;
                    wait_cnt <= '0;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_RST;
                end
            endcase
        end
    end

    // Decode state and latched class into the datapath enables.
    // ALUop and ALUSrc keep their EXEC value through MEM and WB.
    always_comb begin
        ALUop        = 2'b00;
        Reg2Loc      = 1'b0;
        ALUSrc       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        Branch       = 1'b0;
        UncondBranch = 1'b0;
        InstrDone    = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_EXEC: begin
                case (cls)
                    C_R: begin
                        ALUop = 2'b10;
                    end
                    C_LDUR: begin
                        ALUSrc = 1'b1;
                    end
                    C_STUR: begin
                        ALUSrc  = 1'b1;
                        Reg2Loc = 1'b1;
                    end
                    C_CBZ: begin
                        ALUop     = 2'b01;
                        Reg2Loc   = 1'b1;
                        Branch    = 1'b1;
                        InstrDone = 1'b1;
                    end
                    C_B: begin
                        UncondBranch = 1'b1;
                        InstrDone    = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            S_MEM: begin
                ALUSrc   = 1'b1;
                MemRead  = (cls == C_LDUR);
                MemWrite = (cls == C_STUR);
                // A store ends in MEM; the done pulse marks the accepted write.
                InstrDone = (cls == C_STUR) && MemReady;
            end
            S_WB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                if (cls == C_LDUR) begin
                    MemtoReg = 1'b1;
                    ALUSrc   = 1'b1;
                end else begin
                    ALUop = 2'b10;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// Each scenario fills a table of per-cycle inputs and the expected
// {State, enables, Illegal, BusErr}, then checks it cycle by cycle.
module tb_multicycle_control;

    logic        CLK;
    logic        Reset;
    logic [10:0] Opcode;
    logic        MemReady;
    logic [1:0]  ALUop;
    logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
    logic        IRWrite, PCWrite, Branch, UncondBranch, InstrDone;
    logic        Illegal, BusErr;
    logic [2:0]  State;

    multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .ALUop(ALUop), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
        .UncondBranch(UncondBranch), .InstrDone(InstrDone),
        .Illegal(Illegal), .BusErr(BusErr), .State(State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control bits, MSB first: ALUop[1:0] Reg2Loc ALUSrc MemtoReg RegWrite MemRead
    // MemWrite IRWrite PCWrite Branch UncondBranch InstrDone
    wire [12:0] ctrl = {ALUop, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead,
                        MemWrite, IRWrite, PCWrite, Branch, UncondBranch, InstrDone};
    wire [17:0] obs  = {State, ctrl, Illegal, BusErr};

    localparam logic [12:0] K_NONE = 13'h0000;
    localparam logic [12:0] K_OP10 = 13'h1000;
    localparam logic [12:0] K_OP01 = 13'h0800;
    localparam logic [12:0] K_R2L  = 13'h0400;
    localparam logic [12:0] K_SRC  = 13'h0200;
    localparam logic [12:0] K_M2R  = 13'h0100;
    localparam logic [12:0] K_RW   = 13'h0080;
    localparam logic [12:0] K_MR   = 13'h0040;
    localparam logic [12:0] K_MW   = 13'h0020;
    localparam logic [12:0] K_IR   = 13'h0010;
    localparam logic [12:0] K_PC   = 13'h0008;
    localparam logic [12:0] K_BR   = 13'h0004;
    localparam logic [12:0] K_UB   = 13'h0002;
    localparam logic [12:0] K_ID   = 13'h0001;

    localparam logic [2:0] ST_RST = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2,
                           ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd6;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010110110;
    localparam logic [10:0] OP_BAD  = 11'b00000000000;

    int compared   = 0;
    int mismatched = 0;

    logic [10:0] opc_t [40];
    logic        mr_t  [40];
    logic [17:0] exp_t [40];
    int          n_rows;

    // Append one cycle of stimulus and expected outputs to the table.
    task automatic add_row(input logic [10:0] opc, input logic mr, input logic [2:0] st,
                           input logic [12:0] c, input logic il, input logic be);
        opc_t[n_rows] = opc;
        mr_t[n_rows]  = mr;
        exp_t[n_rows] = {st, c, il, be};
        n_rows++;
    endtask

    // Pulse reset and release it on a falling edge; the machine then sits in RST.
    task automatic do_reset();
        Reset = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Opcode = OP_ADD;
        MemReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            #1;
            compared++;
            if (obs !== 18'h0) begin
                mismatched++;
                $display("FAIL reset_hold cyc %0d: got %h want %h", i, obs, 18'h0);
            end
        end
    endtask

    task automatic test_add();
        n_rows = 0;
        add_row(OP_ADD, 1'b1, ST_RST,   K_NONE,               1'b0, 1'b0);
        add_row(OP_ADD, 1'b1, ST_FETCH, K_MR | K_IR | K_PC,   1'b0, 1'b0);
        add_row(OP_ADD, 1'b1, ST_DEC,   K_NONE,               1'b0, 1'b0);
        add_row(OP_ADD, 1'b1, ST_EXEC,  K_OP10,               1'b0, 1'b0);
        add_row(OP_ADD, 1'b1, ST_WB,    K_OP10 | K_RW | K_ID, 1'b0, 1'b0);
        add_row(OP_ADD, 1'b1, ST_FETCH, K_MR | K_IR | K_PC,   1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < n_rows; i++) begin
            Opcode = opc_t[i];
            MemReady = mr_t[i];
            #1;
            compared++;
            if (obs !== exp_t[i]) begin
                mismatched++;
                $display("FAIL add cyc %0d: got %h want %h", i, obs, exp_t[i]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_ldur();
        n_rows = 0;
        add_row(OP_LDUR, 1'b1, ST_RST,   K_NONE,                       1'b0, 1'b0);
        add_row(OP_LDUR, 1'b1, ST_FETCH, K_MR | K_IR | K_PC,           1'b0, 1'b0);
        add_row(OP_LDUR, 1'b0, ST_DEC,   K_NONE,                       1'b0, 1'b0);
        add_row(OP_LDUR, 1'b0, ST_EXEC,  K_SRC,                        1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            add_row(OP_LDUR, 1'b0, ST_MEM, K_MR | K_SRC,               1'b0, 1'b0);
        add_row(OP_LDUR, 1'b1, ST_MEM,   K_MR | K_SRC,                 1'b0, 1'b0);
        add_row(OP_LDUR, 1'b0, ST_WB,    K_RW | K_M2R | K_ID | K_SRC,  1'b0, 1'b0);
        add_row(OP_LDUR, 1'b0, ST_FETCH, K_MR,                         1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < n_rows; i++) begin
            Opcode = opc_t[i];
            MemReady = mr_t[i];
            #1;
            compared++;
            if (obs !== exp_t[i]) begin
                mismatched++;
                $display("FAIL ldur cyc %0d: got %h want %h", i, obs, exp_t[i]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_stur();
        n_rows = 0;
        add_row(OP_STUR, 1'b1, ST_RST,   K_NONE,               1'b0, 1'b0);
        add_row(OP_STUR, 1'b1, ST_FETCH, K_MR | K_IR | K_PC,   1'b0, 1'b0);
        add_row(OP_STUR, 1'b0, ST_DEC,   K_NONE,               1'b0, 1'b0);
        add_row(OP_STUR, 1'b0, ST_EXEC,  K_SRC | K_R2L,        1'b0, 1'b0);
        add_row(OP_STUR, 1'b0, ST_MEM,   K_MW | K_SRC,         1'b0, 1'b0);
        add_row(OP_STUR, 1'b1, ST_MEM,   K_MW | K_SRC | K_ID,  1'b0, 1'b0);
        add_row(OP_STUR, 1'b0, ST_FETCH, K_MR,                 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < n_rows; i++) begin
            Opcode = opc_t[i];
            MemReady = mr_t[i];
            #1;
            compared++;
            if (obs !== exp_t[i]) begin
                mismatched++;
                $display("FAIL stur cyc %0d: got %h want %h", i, obs, exp_t[i]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_back_to_back_branches();
        n_rows = 0;
        add_row(OP_CBZ, 1'b1, ST_RST,   K_NONE,                           1'b0, 1'b0);
        add_row(OP_CBZ, 1'b1, ST_FETCH, K_MR | K_IR | K_PC,               1'b0, 1'b0);
        add_row(OP_CBZ, 1'b1, ST_DEC,   K_NONE,                           1'b0, 1'b0);
        add_row(OP_CBZ, 1'b1, ST_EXEC,  K_OP01 | K_R2L | K_BR | K_ID,     1'b0, 1'b0);
        add_row(OP_CBZ, 1'b1, ST_FETCH, K_MR | K_IR | K_PC,               1'b0, 1'b0);
        add_row(OP_B,   1'b1, ST_DEC,   K_NONE,                           1'b0, 1'b0);
        add_row(OP_B,   1'b0, ST_EXEC,  K_UB | K_ID,                      1'b0, 1'b0);
        add_row(OP_B,   1'b0, ST_FETCH, K_MR,                             1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < n_rows; i++) begin
            Opcode = opc_t[i];
            MemReady = mr_t[i];
            #1;
            compared++;
            if (obs !== exp_t[i]) begin
                mismatched++;
                $display("FAIL branch cyc %0d: got %h want %h", i, obs, exp_t[i]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_illegal();
        n_rows = 0;
        add_row(OP_BAD, 1'b1, ST_RST,   K_NONE,             1'b0, 1'b0);
        add_row(OP_BAD, 1'b1, ST_FETCH, K_MR | K_IR | K_PC, 1'b0, 1'b0);
        add_row(OP_BAD, 1'b1, ST_DEC,   K_NONE,             1'b0, 1'b0);
        for (int k = 0; k < 20; k++)
            add_row(OP_ADD, 1'b1, ST_TRAP, K_NONE,          1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < n_rows; i++) begin
            Opcode = opc_t[i];
            MemReady = mr_t[i];
            #1;
            compared++;
            if (obs !== exp_t[i]) begin
                mismatched++;
                $display("FAIL illegal cyc %0d: got %h want %h", i, obs, exp_t[i]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_fetch_timeout();
        n_rows = 0;
        add_row(OP_ADD, 1'b0, ST_RST, K_NONE, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++)
            add_row(OP_ADD, 1'b0, ST_FETCH, K_MR, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            add_row(OP_ADD, 1'b1, ST_TRAP, K_NONE, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < n_rows; i++) begin
            Opcode = opc_t[i];
            MemReady = mr_t[i];
            #1;
            compared++;
            if (obs !== exp_t[i]) begin
                mismatched++;
                $display("FAIL fetch_timeout cyc %0d: got %h want %h", i, obs, exp_t[i]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_fetch_late_ready();
        n_rows = 0;
        add_row(OP_ADD, 1'b0, ST_RST, K_NONE, 1'b0, 1'b0);
        for (int k = 0; k < 14; k++)
            add_row(OP_ADD, 1'b0, ST_FETCH, K_MR, 1'b0, 1'b0);
        add_row(OP_ADD, 1'b1, ST_FETCH, K_MR | K_IR | K_PC, 1'b0, 1'b0);
        add_row(OP_ADD, 1'b0, ST_DEC,   K_NONE,             1'b0, 1'b0);
        add_row(OP_ADD, 1'b0, ST_EXEC,  K_OP10,             1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < n_rows; i++) begin
            Opcode = opc_t[i];
            MemReady = mr_t[i];
            #1;
            compared++;
            if (obs !== exp_t[i]) begin
                mismatched++;
                $display("FAIL fetch_late cyc %0d: got %h want %h", i, obs, exp_t[i]);
            end
            @(negedge CLK);
        end
    endtask

    // Reset lands mid-MEM of a store while MemWrite is high; outputs drop before any edge.
    task automatic test_async_reset();
        n_rows = 0;
        add_row(OP_STUR, 1'b1, ST_RST,   K_NONE,             1'b0, 1'b0);
        add_row(OP_STUR, 1'b1, ST_FETCH, K_MR | K_IR | K_PC, 1'b0, 1'b0);
        add_row(OP_STUR, 1'b0, ST_DEC,   K_NONE,             1'b0, 1'b0);
        add_row(OP_STUR, 1'b0, ST_EXEC,  K_SRC | K_R2L,      1'b0, 1'b0);
        add_row(OP_STUR, 1'b0, ST_MEM,   K_MW | K_SRC,       1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < n_rows; i++) begin
            Opcode = opc_t[i];
            MemReady = mr_t[i];
            #1;
            compared++;
            if (obs !== exp_t[i]) begin
                mismatched++;
                $display("FAIL async_reset_pre cyc %0d: got %h want %h", i, obs, exp_t[i]);
            end
            @(negedge CLK);
        end
        MemReady = 1'b0;
        #1;
        compared++;
        if (obs !== {ST_MEM, K_MW | K_SRC, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL async_reset_mem: got %h want %h", obs, {ST_MEM, K_MW | K_SRC, 1'b0, 1'b0});
        end
        Reset = 1'b1;
        #1;
        compared++;
        if (obs !== 18'h0) begin
            mismatched++;
            $display("FAIL async_reset_drop: got %h want %h", obs, 18'h0);
        end
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        compared++;
        if (obs !== 18'h0) begin
            mismatched++;
            $display("FAIL async_reset_rst: got %h want %h", obs, 18'h0);
        end
        @(negedge CLK);
        #1;
        compared++;
        if (obs !== {ST_FETCH, K_MR, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL async_reset_fetch: got %h want %h", obs, {ST_FETCH, K_MR, 1'b0, 1'b0});
        end
        @(negedge CLK);
    endtask

    initial begin
        Reset = 1'b1;
        Opcode = '0;
        MemReady = 1'b0;
        test_reset();
        test_add();
        test_ldur();
        test_stur();
        test_back_to_back_branches();
        test_illegal();
        test_fetch_timeout();
        test_fetch_late_ready();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
